// File: rtl/intan_rhd2216_spi_responder.sv
//==============================================================================
// Module   : intan_rhd2216_spi_responder
// Purpose  : Synthesizable stand-in for the RHD2216 SPI slave (chip side of the
//            Intan command link). It oversamples the SPI pins on FPGA_CLK,
//            decodes 16-bit commands and keeps an 18-entry register file,
//            read-only ID registers and per-channel ADC test counters. Each
//            accepted command's result is shifted out two frames later.
// Ports    : FPGA_CLK   - system clock, oversamples the SPI pins
//            RESET_N    - asynchronous active-low reset
//            INTAN_CLK  - SPI SCLK from the master (mode 0, idles low)
//            CS         - chip select, active low, high between frames
//            MOSI       - command bit from the master, MSB first
//            MISO       - result bit to the master, MSB first
//            CMD_STROBE - one-cycle pulse when a full 16-bit frame is accepted
//            LAST_CMD   - last accepted command, updated with CMD_STROBE
//            FRAME_ERR  - one-cycle pulse when CS rises with bit count != 16
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module intan_rhd2216_spi_responder #(
    parameter logic [7:0] CHIP_ID  = 8'd2,
    parameter logic [7:0] NUM_AMPS = 8'd16,
    parameter logic [7:0] DIE_REV  = 8'd1,
    parameter logic [7:0] UNIPOLAR = 8'd1
) (
    input  logic        FPGA_CLK,
    input  logic        RESET_N,
    input  logic        INTAN_CLK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        CMD_STROBE,
    output logic [15:0] LAST_CMD,
    output logic        FRAME_ERR
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Pin synchronizers plus one history flop for edge detection.
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cs_meta_q,   cs_sync_q,   cs_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

    state_t             state_q,   state_d;
    logic [4:0]         bitcnt_q,  bitcnt_d;
    logic [15:0]        rx_q,      rx_d;
    logic [15:0]        tx_q,      tx_d;
    logic               strobe_q,  strobe_d;
    logic               ferr_q,    ferr_d;
    logic [15:0]        last_q,    last_d;
    logic [15:0]        pipe0_q,   pipe0_d;
    logic [15:0]        pipe1_q,   pipe1_d;
    logic [3:0]         cal_q,     cal_d;
    logic [17:0][7:0]   regfile_q, regfile_d;
    logic [15:0][11:0]  cnt_q,     cnt_d;

    logic [15:0]        w_result;
    logic [7:0]         w_rdval;
    logic [5:0]         w_ch;

    always_ff @(posedge FPGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            // CS history resets low so a frame already running when reset is
            // released never produces a fall; its closing rise lands in IDLE
            // and is ignored.
            cs_meta_q   <= 1'b0;
            cs_sync_q   <= 1'b0;
            cs_prev_q   <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= INTAN_CLK;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= CS;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            mosi_meta_q <= MOSI;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign w_sclk_rise =  sclk_sync_q & ~sclk_prev_q;
    assign w_sclk_fall = ~sclk_sync_q &  sclk_prev_q;
    assign w_cs_rise   =  cs_sync_q   & ~cs_prev_q;
    assign w_cs_fall   = ~cs_sync_q   &  cs_prev_q;

    assign w_ch = rx_q[13:8];

    // Read-back value for a READ of register w_ch.
    always_comb begin
        w_rdval = 8'h00;
        if (w_ch < 6'd18) begin
            w_rdval = regfile_q[w_ch[4:0]];
        end else begin
            case (w_ch)
                6'd40:   w_rdval = 8'h49;   // 'I'
                6'd41:   w_rdval = 8'h4E;   // 'N'
                6'd42:   w_rdval = 8'h54;   // 'T'
                6'd43:   w_rdval = 8'h41;   // 'A'
                6'd44:   w_rdval = 8'h4E;   // 'N'
                6'd60:   w_rdval = DIE_REV;
                6'd61:   w_rdval = UNIPOLAR;
                6'd62:   w_rdval = NUM_AMPS;
                6'd63:   w_rdval = CHIP_ID;
                default: w_rdval = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        strobe_d  = 1'b0;
        ferr_d    = 1'b0;
        last_d    = last_q;
        pipe0_d   = pipe0_q;
        pipe1_d   = pipe1_q;
        cal_d     = cal_q;
        regfile_d = regfile_q;
        cnt_d     = cnt_q;
        w_result  = 16'h0000;

        case (state_q)
            ST_IDLE: begin
                // tx stays zero in IDLE, which keeps MISO low while CS is high.
                if (w_cs_fall) begin
                    state_d  = ST_SHIFT;
                    bitcnt_d = 5'd0;
                    tx_d     = pipe1_q;
                end
            end

            ST_SHIFT: begin
                if (w_cs_rise) begin
                    state_d = ST_IDLE;
                    tx_d    = 16'h0000;
                    if (bitcnt_q == 5'd16) begin
                        strobe_d = 1'b1;
                        last_d   = rx_q;
                        case (rx_q[15:14])
                            2'b00: begin
                                // CONVERT: calibration swallows conversions.
                                if (cal_q != 4'd0) begin
                                    cal_d = cal_q - 4'd1;
                                end else if (w_ch < 6'd16) begin
                                    w_result = {w_ch[3:0], cnt_q[w_ch[3:0]]};
                                    cnt_d[w_ch[3:0]] = cnt_q[w_ch[3:0]] + 12'd1;
                                end else if (w_ch >= 6'd32) begin
                                    w_result = {10'b0, w_ch};
                                end
                            end
                            2'b01: begin
                                if (rx_q == 16'h5500) begin
                                    cal_d = 4'd9;
                                end else if (rx_q == 16'h6A00) begin
                                    cnt_d = '0;
                                end
                            end
                            2'b10: begin
                                if (w_ch < 6'd18) begin
                                    regfile_d[w_ch[4:0]] = rx_q[7:0];
                                end
                                w_result = {8'hFF, rx_q[7:0]};
                            end
                            default: begin
                                w_result = {8'h00, w_rdval};
                            end
                        endcase
                        pipe1_d = pipe0_q;
                        pipe0_d = w_result;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    if (w_sclk_rise) begin
                        rx_d = {rx_q[14:0], mosi_sync_q};
                        if (bitcnt_q != 5'd31) begin
                            bitcnt_d = bitcnt_q + 5'd1;
                        end
                    end
                    if (w_sclk_fall) begin
                        tx_d = {tx_q[14:0], 1'b0};
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge FPGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= 5'd0;
            rx_q      <= 16'h0000;
            tx_q      <= 16'h0000;
            strobe_q  <= 1'b0;
            ferr_q    <= 1'b0;
            last_q    <= 16'h0000;
            pipe0_q   <= 16'h0000;
            pipe1_q   <= 16'h0000;
            cal_q     <= 4'd0;
            regfile_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            strobe_q  <= strobe_d;
            ferr_q    <= ferr_d;
            last_q    <= last_d;
            pipe0_q   <= pipe0_d;
            pipe1_q   <= pipe1_d;
            cal_q     <= cal_d;
            regfile_q <= regfile_d;
            cnt_q     <= cnt_d;
        end
    end

    assign MISO       = tx_q[15];
    assign CMD_STROBE = strobe_q;
    assign LAST_CMD   = last_q;
    assign FRAME_ERR  = ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_intan_rhd2216_spi_responder.sv
//==============================================================================
// Module   : tb_intan_rhd2216_spi_responder
// Purpose  : Directed self-checking bench for intan_rhd2216_spi_responder.
//            Acts as a mode-0 SPI master and compares each frame's MISO word
//            against hand-computed results from two frames earlier.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_intan_rhd2216_spi_responder;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        sclk   = 1'b0;
    logic        cs     = 1'b1;
    logic        mosi   = 1'b0;
    logic        miso;
    logic        strobe;
    logic        ferr;
    logic [15:0] last_cmd;

    int          n_total  = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          n_strobe = 0;
    int          n_ferr   = 0;
    int          base_s;
    int          base_f;
    logic        miso_mid = 1'b0;

    always #5 clk = ~clk;

    intan_rhd2216_spi_responder dut (
        .FPGA_CLK   (clk),
        .RESET_N    (rst_n),
        .INTAN_CLK  (sclk),
        .CS         (cs),
        .MOSI       (mosi),
        .MISO       (miso),
        .CMD_STROBE (strobe),
        .LAST_CMD   (last_cmd),
        .FRAME_ERR  (ferr)
    );

    always @(negedge clk) begin
        if (strobe) n_strobe++;
        if (ferr)   n_ferr++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // One SPI frame of nbits clocks; MISO is captured just before each rise.
    // rst_bit >= 0 pulses RESET_N low for 2 cycles before that bit's rise.
    task automatic frame(input logic [15:0] cmd, input int nbits, input int rst_bit,
                         output logic [15:0] rxw);
        rxw = 16'h0000;
        @(negedge clk);
        cs = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? cmd[15-i] : 1'b0;
            if (i == rst_bit) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                miso_mid = miso;
            end
            repeat (4) @(negedge clk);
            if (i < 16) rxw[15-i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic xfer(input logic [15:0] cmd, input logic [15:0] exp, input string tag);
        logic [15:0] w;
        frame(cmd, 16, -1, w);
        check(tag, w, exp);
    endtask

    logic [15:0] junk;

    initial begin
        // ---- Reset state, WRITE then READ ----
        do_reset();
        check("rst_miso",   {15'b0, miso},   16'h0000);
        check("rst_strobe", {15'b0, strobe}, 16'h0000);
        check("rst_ferr",   {15'b0, ferr},   16'h0000);
        check("rst_last",   last_cmd,        16'h0000);
        xfer(16'h8103, 16'h0000, "wr_f1");
        xfer(16'hC100, 16'h0000, "wr_f2");
        check("last_cmd_read", last_cmd, 16'hC100);
        xfer(16'h0000, 16'hFF03, "wr_f3");
        xfer(16'h0000, 16'h0003, "wr_f4");
        check("strobe_count", 16'(n_strobe), 16'd4);

        // ---- ROM registers ----
        do_reset();
        xfer(16'hE800, 16'h0000, "rom_f1");
        xfer(16'hE900, 16'h0000, "rom_f2");
        xfer(16'hEA00, 16'h0049, "rom_r40");
        xfer(16'hEB00, 16'h004E, "rom_r41");
        xfer(16'hEC00, 16'h0054, "rom_r42");
        xfer(16'hFF00, 16'h0041, "rom_r43");
        xfer(16'hFE00, 16'h004E, "rom_r44");
        xfer(16'hFC00, 16'h0002, "rom_r63");
        xfer(16'hC000, 16'h0010, "rom_r62");
        xfer(16'hC000, 16'h0001, "rom_r60");

        // ---- Regfile edges: reg 17 writable, reg 18 not ----
        do_reset();
        xfer(16'h9155, 16'h0000, "rf_f1");
        xfer(16'h92AA, 16'h0000, "rf_f2");
        xfer(16'hD100, 16'hFF55, "rf_wr17");
        xfer(16'hD200, 16'hFFAA, "rf_wr18");
        xfer(16'hC000, 16'h0055, "rf_rd17");
        xfer(16'hC000, 16'h0000, "rf_rd18");

        // ---- CONVERT test pattern ----
        do_reset();
        xfer(16'h0300, 16'h0000, "cv_f1");
        xfer(16'h0300, 16'h0000, "cv_f2");
        xfer(16'h0300, 16'h3000, "cv_ch3_0");
        xfer(16'h0300, 16'h3001, "cv_ch3_1");
        xfer(16'h3F00, 16'h3002, "cv_ch3_2");
        xfer(16'h1000, 16'h3003, "cv_ch3_3");
        xfer(16'h0F00, 16'h003F, "cv_ch63");
        xfer(16'hC000, 16'h0000, "cv_ch16");
        xfer(16'hC000, 16'hF000, "cv_ch15");

        // ---- CALIBRATE and CLEAR ----
        do_reset();
        xfer(16'h5500, 16'h0000, "cal_cmd");
        for (int k = 0; k < 9; k++) xfer(16'h0000, 16'h0000, "cal_busy");
        xfer(16'h0000, 16'h0000, "cal_f11");
        xfer(16'h0000, 16'h0000, "cal_f12");
        xfer(16'hC000, 16'h0000, "cal_first");
        xfer(16'hC000, 16'h0001, "cal_second");
        xfer(16'h6A00, 16'h0000, "clr_f15");
        xfer(16'h0000, 16'h0000, "clr_f16");
        xfer(16'hC000, 16'h0000, "clr_f17");
        xfer(16'hC000, 16'h0000, "clr_cnt0");

        // ---- Short and long frames ----
        do_reset();
        xfer(16'h8142, 16'h0000, "fe_f1");
        xfer(16'hC100, 16'h0000, "fe_f2");
        base_s = n_strobe;
        base_f = n_ferr;
        frame(16'h8177, 10, -1, junk);
        check("fe_short_ferr",   16'(n_ferr - base_f),   16'd1);
        check("fe_short_strobe", 16'(n_strobe - base_s), 16'd0);
        check("fe_short_last",   last_cmd,               16'hC100);
        xfer(16'hC000, 16'hFF42, "fe_pipe1_kept");
        frame(16'h81FF, 20, -1, junk);
        check("fe_long_ferr",    16'(n_ferr - base_f),   16'd2);
        check("fe_long_strobe",  16'(n_strobe - base_s), 16'd1);
        xfer(16'hC100, 16'h0042, "fe_after_long");
        xfer(16'hC000, 16'h0000, "fe_rd0");
        xfer(16'hC000, 16'h0042, "fe_reg1_kept");

        // ---- Reset in the middle of a frame ----
        do_reset();
        xfer(16'h8105, 16'h0000, "mr_f1");
        xfer(16'hC100, 16'h0000, "mr_f2");
        base_s = n_strobe;
        base_f = n_ferr;
        frame(16'h8005, 16, 7, junk);
        check("mr_miso",   {15'b0, miso_mid},      16'h0000);
        check("mr_strobe", 16'(n_strobe - base_s), 16'd0);
        check("mr_ferr",   16'(n_ferr - base_f),   16'd0);
        check("mr_last",   last_cmd,               16'h0000);
        xfer(16'hC000, 16'h0000, "mr_pipe1");
        xfer(16'hC000, 16'h0000, "mr_pipe0");
        xfer(16'hC000, 16'h0000, "mr_reg0");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
